irq_ctrl: RTL
=============

Name: irq_ctrl

Overview:
Interrupt controller for the 5-stage MIPS pipeline.
- Latches edge events from N_SRC external interrupt sources and applies a software-writable mask.
- Picks one winner by fixed priority.
- Waits for a safe pipeline point (no load-use stall, no branch/jump flush in flight), then pulses `irq` into the hazard unit and PC mux for one cycle.
- Captures EPC and cause on that pulse, then blocks further interrupts until `eret`.

Parameters:
- N_SRC, 4, number of interrupt sources (1..8)
- CAUSE_W, 3, width of cause index; must satisfy 2^CAUSE_W >= N_SRC
- MASK_RST, {N_SRC{1'b1}}, mask register value after reset

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- irq_src  in  N_SRC  raw interrupt lines, level; rising edge = event
- mask_we  in  1  write strobe for mask register
- mask_wdata  in  N_SRC  new mask value; 1 = source enabled
- pipe_stall  in  1  1 while PC/IF-ID write is blocked (load-use bubble)
- pipe_flush  in  1  1 while a taken branch or jump flush is in progress
- epc_in  in  32  PC of the instruction to resume at; sampled on issue
- eret  in  1  one-cycle pulse from ID when eret decodes
- irq  out  1  one-cycle request to hazard unit/PC mux
- cause  out  CAUSE_W  index of the serviced source
- epc  out  32  saved return PC
- in_service  out  1  high from the irq cycle until eret is accepted
- pending  out  N_SRC  current pending register, for debug/CP0 read

Behaviour:
Reset (reset==0 at a clock edge):
- State = IDLE; irq=0, cause=0, epc=0, in_service=0, pending=0, mask=MASK_RST.
- Edge-detect history is cleared to 0; a source held high through reset therefore fires once after reset.

Pending register:
- pending[i] sets when irq_src[i] is 1 now and was 0 at the previous edge.
- pending[i] clears when source i wins ISSUE.
- If set and clear hit the same bit in the same cycle, set wins.
- Pending bits latch regardless of mask.
- mask_we updates the mask at the edge; the new mask takes effect from the next cycle.

Winner selection:
- eligible = pending & mask.
- Lowest index has highest priority.
- The winner is re-evaluated at ARM->ISSUE, so a higher-priority event arriving during ARM wins.

State machine (registered, one transition per edge):
- IDLE -> ARM when eligible != 0.
- ARM -> IDLE when eligible == 0 (masked away).
- ARM -> ISSUE when pipe_stall==0 and pipe_flush==0; otherwise stay in ARM.
- ISSUE: irq=1 for exactly this cycle. On entry, the following are latched:
  - cause = winner index
  - epc = epc_in
  - pending[winner] cleared
  - in_service = 1
- ISSUE -> SERVICE unconditionally.
- SERVICE -> IDLE on eret; in_service drops in the cycle after the eret edge.
- eret is ignored in IDLE, ARM and ISSUE.

Latency: an edge sampled at clock edge k gives pending=1 after k, ARM after k+1, irq high in the cycle after k+2 (minimum 3 edges).

Boundary cases:
- eret together with a new eligible event: go to IDLE first, then ARM on the next edge; no state is skipped.
- Mid-operation reset: an irq pulse is aborted and epc is cleared.
- All sources masked: the controller never leaves IDLE, but pending still accumulates.

Optional Feature:
IRQ_SYNC_EN
- Defined: irq_src passes through a 2-flop synchronizer per bit before edge detection; minimum latency becomes 5 edges; the synchronizer flops reset to 0.
- Undefined: irq_src is assumed synchronous to clk and feeds edge detection directly.

Decomposition:
- Shared package irq_pkg:
  - state encoding IDLE=2'd0, ARM=2'd1, ISSUE=2'd2, SERVICE=2'd3
  - default exception vector constant IRQ_VEC=32'h8000_0004, for the PC mux
- Sub-module irq_prio_enc (N_SRC-bit eligible in, valid + CAUSE_W index out, lowest index first), purely combinational.

Test Plan:
1. Reset held low 2 cycles, release -> irq=0, pending=0, mask=4'b1111, in_service=0.
2. irq_src[2] rises before edge 1, stall/flush=0, epc_in=32'h0040_0010 -> irq high in the cycle after edge 3; cause=2; epc=32'h0040_0010; pending=0; in_service=1.
3. irq_src[3] and irq_src[1] rise together -> cause=1 issued, pending=4'b1000; pulse eret -> in_service=0, then second irq with cause=3 three edges later.
4. Event on src 0 with pipe_stall=1 for 4 cycles and pipe_flush=1 on the 5th -> stays in ARM with irq=0 throughout; irq fires on the first cycle after both are 0.
5. mask_wdata=4'b0000 written, then irq_src[0] rises -> pending=4'b0001, no irq; write mask 4'b0001 -> irq with cause=0 three edges later.
6. In SERVICE, new event on src 1 -> no irq until eret; eret plus simultaneous src 2 edge -> IDLE, then ARM, then irq with cause=1 (higher priority pending).

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and constants for the MIPS interrupt controller.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        ISSUE   = 2'd2,
        SERVICE = 2'd3
    } irq_state_t;

    // Exception vector that the PC mux selects when irq is taken.
    localparam logic [31:0] IRQ_VEC = 32'h8000_0004;

endpackage

// File: rtl/irq_ctrl_if.sv
// Pipeline-facing signal bundle of the interrupt controller.
// The controller takes the slave modport; whoever drives the sources and pipeline status takes master.
interface irq_ctrl_if #(
    parameter int N_SRC   = 4,
    parameter int CAUSE_W = 3
);
    logic [N_SRC-1:0]   irq_src;
    logic               mask_we;
    logic [N_SRC-1:0]   mask_wdata;
    logic               pipe_stall;
    logic               pipe_flush;
    logic [31:0]        epc_in;
    logic               eret;
    logic               irq;
    logic [CAUSE_W-1:0] cause;
    logic [31:0]        epc;
    logic               in_service;
    logic [N_SRC-1:0]   pending;

    modport master (
        output irq_src, mask_we, mask_wdata, pipe_stall, pipe_flush, epc_in, eret,
        input  irq, cause, epc, in_service, pending
    );

    modport slave (
        input  irq_src, mask_we, mask_wdata, pipe_stall, pipe_flush, epc_in, eret,
        output irq, cause, epc, in_service, pending
    );
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins. Purely combinational.
module irq_prio_enc #(
    parameter int N_SRC   = 4,
    parameter int CAUSE_W = 3
) (
    input  logic [N_SRC-1:0]   i_eligible,
    output logic               o_valid,
    output logic [CAUSE_W-1:0] o_idx
);

    always_comb begin
        o_valid = |i_eligible;
        o_idx   = '0;
        // Scan downwards so the lowest set bit is the last assignment.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (i_eligible[i]) begin
                o_idx = CAUSE_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller for the 5-stage MIPS pipeline: edge-latched pending bits, mask,
// fixed priority, issue at a safe pipeline point. Define IRQ_SYNC_EN for 2-flop input synchronizers.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int               N_SRC    = 4,
    parameter int               CAUSE_W  = 3,
    parameter logic [N_SRC-1:0] MASK_RST = {N_SRC{1'b1}}
) (
    input  logic       clk,
    input  logic       reset,
    irq_ctrl_if.slave  bus
);

    irq_state_t         r_state;
    logic               r_irq;
    logic [CAUSE_W-1:0] r_cause;
    logic [31:0]        r_epc;
    logic               r_in_service;
    logic [N_SRC-1:0]   r_pending;
    logic [N_SRC-1:0]   r_mask;
    logic [N_SRC-1:0]   r_hist;

    logic [N_SRC-1:0]   w_src;
    logic [N_SRC-1:0]   w_rise;
    logic [N_SRC-1:0]   w_eligible;
    logic [N_SRC-1:0]   w_clr;
    logic               w_valid;
    logic [CAUSE_W-1:0] w_idx;
    logic               w_issue;

`ifdef IRQ_SYNC_EN
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_sync
            logic r_meta;
            logic r_stable;
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_meta   <= 1'b0;
                    r_stable <= 1'b0;
                end else begin
                    r_meta   <= bus.irq_src[gi];
                    r_stable <= r_meta;
                end
            end
            assign w_src[gi] = r_stable;
        end
    endgenerate
`else
    assign w_src = bus.irq_src;
`endif

    assign w_rise     = w_src & ~r_hist;
    assign w_eligible = r_pending & r_mask;

    irq_prio_enc #(
        .N_SRC   (N_SRC),
        .CAUSE_W (CAUSE_W)
    ) u_prio (
        .i_eligible (w_eligible),
        .o_valid    (w_valid),
        .o_idx      (w_idx)
    );

    assign w_issue = (r_state == ARM) && w_valid && !bus.pipe_stall && !bus.pipe_flush;

    // Clear only the winning bit; a fresh rise on that same bit still re-sets it below.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_clr
            assign w_clr[gi] = w_issue && (w_idx == CAUSE_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_irq        <= 1'b0;
            r_cause      <= '0;
            r_epc        <= '0;
            r_in_service <= 1'b0;
            r_pending    <= '0;
            r_mask       <= MASK_RST;
            r_hist       <= '0;
        end else begin
            r_hist    <= w_src;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            r_irq     <= 1'b0;
            if (bus.mask_we) begin
                r_mask <= bus.mask_wdata;
            end
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_state <= ARM;
                    end
                end
                ARM: begin
                    if (!w_valid) begin
                        r_state <= IDLE;
                    end else if (w_issue) begin
                        r_state      <= ISSUE;
                        r_irq        <= 1'b1;
                        r_cause      <= w_idx;
                        r_epc        <= bus.epc_in;
                        r_in_service <= 1'b1;
                    end
                end
                ISSUE: begin
                    r_state <= SERVICE;
                end
                SERVICE: begin
                    if (bus.eret) begin
                        r_state      <= IDLE;
                        r_in_service <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.irq        = r_irq;
    assign bus.cause      = r_cause;
    assign bus.epc        = r_epc;
    assign bus.in_service = r_in_service;
    assign bus.pending    = r_pending;

endmodule
